// File: rtl/hdlc_cmd_frame_ctrl.sv
// hdlc_cmd_frame_ctrl: assembles 5-byte command frames from the HDLC receiver and issues register writes
// Ports: clk/rst (async, active-high); s_tvalid/s_tlast/s_tdata byte stream in;
// wr_req/wr_addr/wr_data/wr_ack register-write handshake; frm_done/err_pulse/err_code status;
// cnt_clr clears the saturating ok_cnt/err_cnt counters.
module hdlc_cmd_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE   = 8'h55,
    parameter int         GAP_TIMEOUT = 4096,
    parameter int         ACK_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    input  logic [7:0]  s_tdata,
    output logic        wr_req,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    input  logic        wr_ack,
    output logic        frm_done,
    output logic        err_pulse,
    output logic [2:0]  err_code,
    input  logic        cnt_clr,
    output logic [15:0] ok_cnt,
    output logic [15:0] err_cnt
);
    localparam int GW = (GAP_TIMEOUT > 2) ? $clog2(GAP_TIMEOUT) : 1;
    localparam int AW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);
    localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE, COLLECT, CHECK, WRITE} state_t;
    state_t        state;
    logic [2:0]    idx;
    logic [7:0]    b1, b2, b3, b4;
    logic [GW-1:0] gap_cnt;
    logic [AW-1:0] ack_cnt;
    logic [7:0]    csum;
    logic [2:0]    ev;
    logic          done;
    assign csum = b1 + b2 + b3;
    assign done = (state == WRITE) && wr_req && wr_ack;
    // Error code raised at this edge; a CHECK failure or ack timeout outranks a coincident overrun.
    always_comb begin
        ev = 3'd0;
        case (state)
            IDLE:    ev = !s_tvalid ? 3'd0 : (s_tdata != SYNC_BYTE) ? 3'd1 : s_tlast ? 3'd2 : 3'd0;
            COLLECT: ev = s_tvalid ? (((idx == 3'd4) != s_tlast) ? 3'd2 : 3'd0)
                                   : ((gap_cnt == GAP_LAST) ? 3'd4 : 3'd0);
            CHECK:   ev = (csum != b4) ? 3'd3 : s_tvalid ? 3'd6 : 3'd0;
            default: ev = (wr_req && !wr_ack && ack_cnt == ACK_LAST) ? 3'd5 : s_tvalid ? 3'd6 : 3'd0;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            b1        <= 8'd0;
            b2        <= 8'd0;
            b3        <= 8'd0;
            b4        <= 8'd0;
            gap_cnt   <= '0;
            ack_cnt   <= '0;
            wr_req    <= 1'b0;
            wr_addr   <= 8'd0;
            wr_data   <= 16'd0;
            frm_done  <= 1'b0;
            err_pulse <= 1'b0;
            err_code  <= 3'd0;
            ok_cnt    <= 16'd0;
            err_cnt   <= 16'd0;
        end else begin
            frm_done  <= done;
            err_pulse <= (ev != 3'd0);
            if (ev != 3'd0) err_code <= ev;
            if (cnt_clr) err_cnt <= 16'd0;
            else if (ev != 3'd0 && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (cnt_clr) ok_cnt <= 16'd0;
            else if (done && ok_cnt != 16'hFFFF) ok_cnt <= ok_cnt + 16'd1;
            case (state)
                IDLE: begin
                    if (s_tvalid && ev == 3'd0) begin
                        state   <= COLLECT;
                        idx     <= 3'd1;
                        gap_cnt <= '0;
                    end
                end
                COLLECT: begin
                    if (s_tvalid) begin
                        b1      <= (idx == 3'd1) ? s_tdata : b1;
                        b2      <= (idx == 3'd2) ? s_tdata : b2;
                        b3      <= (idx == 3'd3) ? s_tdata : b3;
                        b4      <= (idx == 3'd4) ? s_tdata : b4;
                        idx     <= idx + 3'd1;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                    if (ev != 3'd0) begin
                        state <= IDLE;
                        idx   <= 3'd0;
                    end else if (s_tvalid && idx == 3'd4) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    idx <= 3'd0;
                    if (csum == b4) begin
                        state   <= WRITE;
                        wr_addr <= b1;
                        wr_data <= {b2, b3};
                        ack_cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    // wr_req rises one cycle after entering WRITE; ack is only looked at once it is up.
                    if (!wr_req) begin
                        wr_req <= 1'b1;
                    end else if (wr_ack || ev == 3'd5) begin
                        wr_req <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + AW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hdlc_cmd_frame_ctrl.sv
// tb_hdlc_cmd_frame_ctrl: directed scoreboard bench for hdlc_cmd_frame_ctrl
module tb_hdlc_cmd_frame_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic [7:0]  s_tdata = 8'd0;
    logic        wr_req;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack = 1'b0;
    logic        frm_done;
    logic        err_pulse;
    logic [2:0]  err_code;
    logic        cnt_clr = 1'b0;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;
    int n_chk = 0;
    int n_err = 0;
    logic [23:0] sb[$];
    hdlc_cmd_frame_ctrl dut (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tdata(s_tdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .frm_done(frm_done), .err_pulse(err_pulse), .err_code(err_code),
        .cnt_clr(cnt_clr), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
    );
    always #5 clk = ~clk;
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
        $fatal(1, "watchdog");
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic send_byte(input logic [7:0] d, input logic l);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask
    task automatic send_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl, input logic [7:0] cs);
        send_byte(8'h55, 1'b0);
        send_byte(a, 1'b0);
        send_byte(dh, 1'b0);
        send_byte(dl, 1'b0);
        send_byte(cs, 1'b1);
    endtask
    task automatic push_good(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl);
        send_frame(a, dh, dl, a + dh + dl);
        sb.push_back({a, dh, dl});
    endtask
    task automatic wait_req(input string tag);
        logic [23:0] e;
        for (int i = 0; i < 10 && !wr_req; i++) tick();
        chk({tag, "_req"}, 32'(wr_req), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : 24'hxxxxxx;
        chk({tag, "_addr"}, 32'(wr_addr), 32'(e[23:16]));
        chk({tag, "_data"}, 32'(wr_data), 32'(e[15:0]));
    endtask
    task automatic ack();
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
    endtask
    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_req", 32'(wr_req), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        chk("rst_err", 32'({frm_done, err_pulse, err_code}), 32'd0);
        chk("rst_cnt", {ok_cnt, err_cnt}, 32'd0);
        // good frame, ack three cycles after wr_req
        push_good(8'h12, 8'hAB, 8'hCD);
        wait_req("f1");
        tick(); tick(); tick();
        chk("f1_hold", 32'(wr_req), 32'd1);
        ack();
        chk("f1_done", 32'(frm_done), 32'd1);
        chk("f1_reqlow", 32'(wr_req), 32'd0);
        chk("f1_ok", 32'(ok_cnt), 32'd1);
        chk("f1_code", 32'(err_code), 32'd0);
        tick();
        chk("f1_done_once", 32'(frm_done), 32'd0);
        // bad checksum, then bad sync
        send_frame(8'h12, 8'hAB, 8'hCD, 8'h8B);
        tick();
        chk("cs_pulse", 32'(err_pulse), 32'd1);
        chk("cs_code", 32'(err_code), 32'd3);
        chk("cs_cnt", 32'(err_cnt), 32'd1);
        tick(); tick();
        chk("cs_noreq", 32'(wr_req), 32'd0);
        send_byte(8'h54, 1'b0);
        chk("sync_code", 32'(err_code), 32'd1);
        chk("sync_cnt", 32'(err_cnt), 32'd2);
        // short frame, then gap timeout
        send_byte(8'h55, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'hAB, 1'b1);
        chk("len_code", 32'(err_code), 32'd2);
        send_byte(8'h55, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        for (int i = 0; i < 4095; i++) tick();
        chk("gap_early", 32'({err_pulse, err_code}), 32'({1'b0, 3'd2}));
        tick();
        chk("gap_pulse", 32'(err_pulse), 32'd1);
        chk("gap_code", 32'(err_code), 32'd4);
        chk("gap_cnt", 32'(err_cnt), 32'd4);
        push_good(8'h01, 8'h02, 8'h03);
        wait_req("f2");
        ack();
        chk("f2_ok", 32'(ok_cnt), 32'd2);
        // ack timeout
        push_good(8'h10, 8'h20, 8'h30);
        wait_req("f3");
        for (int i = 0; i < 255; i++) tick();
        chk("to_hold", 32'(wr_req), 32'd1);
        tick();
        chk("to_reqlow", 32'(wr_req), 32'd0);
        chk("to_code", 32'(err_code), 32'd5);
        chk("to_cnt", 32'(err_cnt), 32'd5);
        // overrun during write, write still completes
        push_good(8'h11, 8'h22, 8'h33);
        wait_req("f4");
        send_byte(8'h99, 1'b0);
        chk("ovr_code", 32'(err_code), 32'd6);
        chk("ovr_cnt", 32'(err_cnt), 32'd6);
        chk("ovr_req", 32'(wr_req), 32'd1);
        chk("ovr_addr", 32'(wr_addr), 32'h11);
        ack();
        chk("ovr_done", 32'(frm_done), 32'd1);
        chk("ovr_ok", 32'(ok_cnt), 32'd3);
        // saturation and clear
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_cnt", {ok_cnt, err_cnt}, 32'd0);
        s_tvalid = 1'b1;
        s_tdata  = 8'h00;
        for (int i = 0; i < 65535; i++) tick();
        s_tvalid = 1'b0;
        chk("sat_full", 32'(err_cnt), 32'hFFFF);
        send_byte(8'h00, 1'b0);
        chk("sat_hold", 32'(err_cnt), 32'hFFFF);
        chk("sat_pulse", 32'(err_pulse), 32'd1);
        cnt_clr = 1'b1;
        send_byte(8'h00, 1'b0);
        cnt_clr = 1'b0;
        chk("clr_win", 32'(err_cnt), 32'd0);
        chk("clr_code", 32'(err_code), 32'd1);
        // async reset during a write
        push_good(8'h40, 8'h00, 8'h01);
        wait_req("f5");
        #2 rst = 1'b1;
        #1;
        chk("arst_req", 32'(wr_req), 32'd0);
        chk("arst_wr", {wr_addr, 8'h00, wr_data}, 32'd0);
        chk("arst_cnt", {ok_cnt, err_cnt}, 32'd0);
        chk("arst_err", 32'({frm_done, err_pulse, err_code}), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        push_good(8'h01, 8'h00, 8'h02);
        wait_req("f6");
        ack();
        chk("f6_ok", 32'(ok_cnt), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/hdlc_cmd_frame_ctrl.md
# hdlc_cmd_frame_ctrl

Command-frame controller sitting downstream of the HDLC command receiver. It consumes the receiver's byte stream (valid/last/data, no backpressure) and assembles fixed 5-byte command frames. It validates sync, length, checksum and inter-byte gap, then sequences a register-write handshake toward the configuration bus. It also keeps saturating good/bad frame counters and reports the last error.

## Interface
Parameters:
- `SYNC_BYTE`, 8'h55, required first byte of every frame
- `GAP_TIMEOUT`, 4096, max clk cycles between consecutive bytes of one frame
- `ACK_TIMEOUT`, 256, max clk cycles `wr_req` may wait for `wr_ack`

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `s_tvalid`  in  1  byte strobe from receiver, one-cycle pulse per byte
- `s_tlast`  in  1  marks last byte of receiver frame, qualified by `s_tvalid`
- `s_tdata`  in  8  received byte, qualified by `s_tvalid`
- `wr_req`  out  1  register-write request, held until ack or timeout
- `wr_addr`  out  8  write address (frame byte 1)
- `wr_data`  out  16  write data {byte 2, byte 3}
- `wr_ack`  in  1  write accepted, sampled only while `wr_req`=1
- `frm_done`  out  1  one-cycle pulse: frame written successfully
- `err_pulse`  out  1  one-cycle pulse on any error
- `err_code`  out  3  last error code, sticky until next error
- `cnt_clr`  in  1  synchronous clear of both counters
- `ok_cnt`  out  16  saturating count of successful frames
- `err_cnt`  out  16  saturating count of errors

## Operation
- Frame: B0=`SYNC_BYTE`, B1=addr, B2=data[15:8], B3=data[7:0], B4=checksum = (B1+B2+B3) mod 256.
- Error codes: 0 none, 1 sync, 2 length, 3 checksum, 4 gap timeout, 5 ack timeout, 6 overrun.
- States: IDLE, COLLECT, CHECK, WRITE.
- IDLE: on `s_tvalid`: B0==SYNC and !`s_tlast` -> COLLECT, idx=1; B0!=SYNC -> err 1; B0==SYNC with `s_tlast` -> err 2; stay IDLE on error.
- COLLECT: each `s_tvalid` stores byte at idx, idx++, gap counter cleared. `s_tlast` with idx<4 -> err 2, IDLE. idx==4 without `s_tlast` -> err 2, IDLE. idx==4 with `s_tlast` -> CHECK. Gap counter reaching `GAP_TIMEOUT` -> err 4, IDLE (partial frame discarded).
- CHECK (1 cycle): checksum match -> WRITE, load `wr_addr`/`wr_data`; mismatch -> err 3, IDLE.
- WRITE: `wr_req`=1, addr/data stable. `wr_ack`=1 -> `frm_done` pulse, `ok_cnt`++, IDLE. Wait counter reaching `ACK_TIMEOUT` -> err 5, IDLE.
- `s_tvalid` in CHECK or WRITE: byte dropped, err 6 (current write continues unaffected); at most one err 6 per cycle.
- Errors: `err_pulse`=1 for one cycle, `err_code` updated same edge, `err_cnt`++.
- Counters: 16-bit, saturate at 16'hFFFF. `cnt_clr` forces 0 and wins over a same-cycle increment.
- Error 6 coinciding with a CHECK error or ack timeout: the non-overrun code is reported, `err_cnt` +1 only.

## Timing
- Reset values: `wr_req`=0, `wr_addr`=0, `wr_data`=0, `frm_done`=0, `err_pulse`=0, `err_code`=0, `ok_cnt`=0, `err_cnt`=0; state IDLE, idx=0.
- B4 sampled at edge N -> CHECK during N..N+1 -> `wr_req` high after edge N+2.
- `wr_ack` high sampled at edge M -> `wr_req` low and `frm_done` high after edge M; next byte accepted in IDLE from edge M+1.
- `wr_ack` outside WRITE is ignored.
- Error detection in IDLE/COLLECT/CHECK: `err_pulse` asserted the cycle after the offending edge.
- Gap timeout fires exactly `GAP_TIMEOUT` cycles after the last accepted byte; ack timeout fires `ACK_TIMEOUT` cycles after `wr_req` rises.
- `rst` mid-frame or mid-write: immediate return to IDLE, `wr_req` drops asynchronously, partial data discarded, counters cleared.

## Test plan
- Frame 55 12 AB CD 8A (tlast on 8A), `wr_ack` 3 cycles after `wr_req` -> `wr_addr`=12, `wr_data`=ABCD, `frm_done` once, `ok_cnt`=1, `err_code`=0.
- Same frame with B4=8B -> no `wr_req`, `err_code`=3, `err_cnt`=1; then a first byte 0x54 -> `err_code`=1, `err_cnt`=2.
- 55 12 AB with tlast on AB -> `err_code`=2; 55 12 AB CD then a gap of `GAP_TIMEOUT` cycles -> `err_code`=4, next valid frame accepted normally.
- Valid frame, `wr_ack` held low -> `wr_req` drops after exactly 256 cycles, `err_code`=5; a byte strobed during WRITE -> `err_code`=6, pending write still completes on ack.
- Preload `err_cnt`=FFFF via 65535 bad sync bytes, one more -> stays FFFF; `cnt_clr` coincident with an error -> `err_cnt`=0.
- Assert `rst` while `wr_req`=1 -> all outputs at reset values in the same cycle; frame 55 01 00 02 03 after release -> `wr_addr`=01, `wr_data`=0002.
